uart_rx: RTL

Asynchronous serial receiver for the board UART. It synchronises `uart_rxd` into the `clk_50mhz` domain, detects and validates start bits, samples 8 data bits LSB-first at mid-bit, checks the stop bit and presents each byte on a valid/ready interface. It sits directly downstream of the `uart_rxd` pin and replaces the pin-level loopback as the first stage of the UART datapath.

---
 rtl/uart_rx_if.sv | 9 +
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Byte handshake between uart_rx and its consumer: data/valid from the receiver, ready back.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, 8 data bits LSB first, valid/ready output.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop (8E1 framing).
module uart_rx #(
  parameter real CLK_FREQUENCY = 50.0e6,
  parameter real BAUD_RATE     = 115200.0
) (
  input  logic          clk_50mhz,
  input  logic          rst_n,
  input  logic          uart_rxd,
  uart_rx_if.master     rx,
  output logic          frame_error,
  output logic          parity_error,
  output logic          overrun
);

  localparam int BIT  = integer'(CLK_FREQUENCY / BAUD_RATE);
  localparam int HALF = BIT / 2;
  localparam int CW   = $clog2(BIT);

  generate
    if (BIT < 4) begin : g_bit_check
      $error("uart_rx: CLK_FREQUENCY/BAUD_RATE must be at least 4");
    end
  endgenerate

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY    = 3'd3;
`endif
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic          sync1_q, rxd_s_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick;
  logic          accept;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  assign tick   = (cnt_q == '0);
  assign accept = valid_q & rx.rx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - CW'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = accept ? 1'b0 : valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          cnt_d   = CW'(HALF - 1);
        end
      end
      S_START: begin
        if (tick) begin
          if (!rxd_s_q) begin
            state_d = S_DATA;
            cnt_d   = CW'(BIT - 1);
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d  = {rxd_s_q, sh_q[7:1]};
          cnt_d = CW'(BIT - 1);
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_bad_d = ^{sh_q, rxd_s_q};
          cnt_d     = CW'(BIT - 1);
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          // Frame error outranks parity; a held byte is never overwritten.
          if (!rxd_s_q) begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            perr_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else if (!valid_q || rx.rx_ready) begin
            data_d  = sh_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ovr_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rxd_s_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= uart_rxd;
      rxd_s_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign rx.rx_data  = data_q;
  assign rx.rx_valid = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule
